// File: rtl/cache_tag_store.sv
// N-way set-associative tag store: per-way synchronous-read tag memories, valid bits,
// tree-PLRU replacement, fill port and whole-array invalidate. Lookups answer one cycle after acceptance.
module cache_tag_store #(
    parameter  int WAYS  = 2,
    parameter  int SETS  = 32,
    parameter  int TAG_W = 23,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             CK,
    input  logic             RSTn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAYS-1:0]  rsp_way,
    output logic [WAYS-1:0]  rsp_victim,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [WAYS-1:0]  fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_all
);
    localparam int LG    = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    // Heap-ordered tree: node n has children 2n+1 (bit=0, lower half) and 2n+2.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [LG-1:0] way);
        logic [NODES-1:0] r;
        int n;
        r = bits;
        n = 0;
        for (int l = 0; l < LG; l++) begin
            r[n] = ~way[LG-1-l];
            n    = 2 * n + 1 + int'(way[LG-1-l]);
        end
        return r;
    endfunction

    function automatic logic [LG-1:0] plru_pick(input logic [NODES-1:0] bits);
        int n;
        n = 0;
        for (int l = 0; l < LG; l++) n = 2 * n + 1 + int'(bits[n]);
        return LG'(n - NODES);
    endfunction

    logic [WAYS-1:0]  valid [SETS];
    logic [NODES-1:0] plru  [SETS];

    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [WAYS-1:0]  valid_q;
    logic [NODES-1:0] plru_q;
    logic [WAYS-1:0]  hit_vec;
    logic [LG-1:0]    hit_sel;
    logic [LG-1:0]    vic_sel;
    logic [LG-1:0]    fill_sel;
    logic             acc;
    logic             hit_upd;

    assign req_ready = !fill_valid && !inv_all;
    assign acc       = req_valid && req_ready;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W-1:0] mem [SETS];
        logic [TAG_W-1:0] q;

        always_ff @(posedge CK) begin
            if (fill_valid && fill_way[w]) mem[fill_idx] <= fill_tag;
            if (acc) q <= mem[req_idx];
        end

        assign hit_vec[w] = valid_q[w] && (q == tag_q);
    end

    // Response state is captured at acceptance so later fills/invalidates leave it intact.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            rsp_valid <= 1'b0;
            tag_q     <= '0;
            idx_q     <= '0;
            valid_q   <= '0;
            plru_q    <= '0;
        end else begin
            rsp_valid <= acc;
            if (acc) begin
                tag_q   <= req_tag;
                idx_q   <= req_idx;
                valid_q <= valid[req_idx];
                plru_q  <= plru[req_idx];
            end
        end
    end

    always_comb begin
        fill_sel = '0;
        for (int w = 0; w < WAYS; w++) if (fill_way[w]) fill_sel = LG'(w);
    end

    always_comb begin
        hit_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--) if (hit_vec[w]) hit_sel = LG'(w);
        vic_sel = plru_pick(plru_q);
        for (int w = WAYS - 1; w >= 0; w--) if (!valid_q[w]) vic_sel = LG'(w);
        rsp_hit = |hit_vec;
        rsp_way = '0;
        if (rsp_hit) rsp_way[hit_sel] = 1'b1;
        rsp_victim = '0;
        rsp_victim[vic_sel] = 1'b1;
    end

    // A fill to the responding set overrides the hit's PLRU touch.
    assign hit_upd = rsp_valid && rsp_hit && !(fill_valid && fill_idx == idx_q);

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else if (inv_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            if (hit_upd) plru[idx_q] <= plru_touch(plru[idx_q], hit_sel);
            if (fill_valid) begin
                valid[fill_idx] <= valid[fill_idx] | fill_way;
                plru[fill_idx]  <= plru_touch(plru[fill_idx], fill_sel);
            end
        end
    end

    a_single_hit: assert property (@(posedge CK) disable iff (!RSTn)
        rsp_valid |-> $onehot0(hit_vec));
    a_fill_onehot: assert property (@(posedge CK) disable iff (!RSTn)
        fill_valid |-> $onehot(fill_way));

endmodule
